mlp_frame_sequencer: RTL and testbench
======================================

Name: mlp_frame_sequencer

Overview:
- Upstream/downstream wrapper for the combinational MLP classifier `top`.
- Accepts features serially, one WIDTH_A-bit word per valid/ready beat, and packs a full frame of NUM_A features into the flat `inp` vector.
- Holds that vector stable and waits a programmable settle time for the combinational classifier.
- Captures the class index and presents it on a valid/ready output port.

Parameters:
- NUM_A, 6, features per frame.
- WIDTH_A, 4, bits per feature (unsigned).
- OUTWIDTH, 2, class index width.
- SETTLE_CYCLES, 4, clock edges between applying a frame and capturing the classifier output; legal range 1..255.
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- s_valid, input, 1, feature beat valid.
- s_ready, output, 1, sequencer can accept a feature.
- s_data, input, WIDTH_A, feature value.
- s_last, input, 1, marks the final feature of a frame.
- mlp_inp, output, NUM_A*WIDTH_A, packed features to the classifier `inp` port.
- mlp_out, input, OUTWIDTH, classifier `out` port.
- m_valid, output, 1, class result valid.
- m_ready, input, 1, consumer accepts the result.
- m_class, output, OUTWIDTH, captured class index.
- frame_err, output, 1, one-cycle pulse when a frame is discarded.
- frame_cnt, output, CNT_W, number of results handed off; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous assert, synchronous deassert by the system):
  - Forces state COLLECT and feature index idx=0.
  - Clears the staging buffer, mlp_inp, m_class, frame_cnt and the settle counter.
  - Outputs: m_valid=0, frame_err=0, s_ready=0 while rst_n=0, s_ready=1 from the first cycle after release.
- State COLLECT:
  - s_ready=1, m_valid=0.
  - A beat is accepted when s_valid & s_ready: s_data is written to staging slot idx and idx increments.
  - Packing: feature k occupies mlp_inp[(k+1)*WIDTH_A-1 : k*WIDTH_A]; the first beat of a frame is k=0.
  - Frame complete: beat at idx=NUM_A-1 with s_last=1.
    - On that same edge, mlp_inp loads all NUM_A features atomically (the new last beat plus staged beats 0..NUM_A-2).
    - The settle counter loads SETTLE_CYCLES, idx returns to 0, state goes to SETTLE.
  - Early last: s_last=1 at idx<NUM_A-1. The beat is consumed, the frame is discarded, idx=0, frame_err=1 for the next cycle, and the state stays COLLECT.
  - Missing last: s_last=0 at idx=NUM_A-1. Same discard behaviour as early last.
  - On any discard, mlp_inp is unchanged, so a partial frame never reaches the classifier.
- State SETTLE:
  - s_ready=0, m_valid=0, mlp_inp held.
  - The counter decrements every edge.
  - On the edge where the counter equals 1, mlp_out is registered into m_class, m_valid becomes 1, and state goes to HOLD.
  - Latency: final beat accepted at edge E0 gives m_valid high just after edge E0+SETTLE_CYCLES.
- State HOLD:
  - s_ready=0; m_valid and m_class are stable until the handshake.
  - On m_valid & m_ready: m_valid=0, frame_cnt increments (0xFFFF goes to 0), state goes to COLLECT, and s_ready=1 next cycle.
  - mlp_inp keeps the last applied frame until the next frame completes.
- General rules:
  - No overlap between frames: s_ready is low from E0 until after the result handshake.
  - s_data, s_last and mlp_out are ignored when no handshake or capture is occurring.
  - Reset asserted in any state aborts all activity immediately. The pending result is lost and frame_cnt is not incremented.

Test Plan:
- Nominal frame:
  - Stimulus: reset, then beats 1,2,3,4,5,6 (s_last on the 6th), mlp_out tied to 2'd2, m_ready=1.
  - Expected: mlp_inp=24'h654321 after E0; m_valid=1 exactly 4 edges later with m_class=2; frame_cnt=1 after the handshake.
- Settle capture timing:
  - Stimulus: mlp_out changes 0->3 at edge E0+3, SETTLE_CYCLES=4.
  - Expected: m_class=3. With the change at E0+5 instead, m_class=0.
- Backpressure:
  - Stimulus: hold m_ready=0 for 10 cycles after m_valid rises; s_valid=1 throughout.
  - Expected: m_valid and m_class stable, s_ready=0, no beats consumed; one handshake on m_ready=1, then s_ready=1.
- Early last:
  - Stimulus: s_last on beat 3 with data A,B,C, then a correct frame 6,5,4,3,2,1.
  - Expected: frame_err pulses once, mlp_inp unchanged by the bad frame, then mlp_inp=24'h123456; frame_cnt increments by 1 only.
- Missing last:
  - Stimulus: 6 beats with s_last=0.
  - Expected: frame_err pulse, state COLLECT, no m_valid.
- Reset mid-SETTLE:
  - Stimulus: drop rst_n two cycles after E0.
  - Expected: immediate m_valid=0, mlp_inp=0, frame_cnt=0; a following nominal frame behaves exactly as in the nominal-frame scenario.

Source files
------------

// File: rtl/mlp_frame_sequencer.sv
// mlp_frame_sequencer: serial-to-frame wrapper around the combinational MLP classifier.
// Collects NUM_A features over a valid/ready stream and applies the whole frame to the
// classifier at once. It then waits SETTLE_CYCLES edges, captures the class index, and
// offers that index on a valid/ready result port.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   s_valid/s_ready        feature beat handshake
//   s_data, s_last         feature value and end-of-frame marker
//   mlp_inp                packed frame to the classifier (feature k at [k*WIDTH_A +: WIDTH_A])
//   mlp_out                classifier class index
//   m_valid/m_ready        result handshake
//   m_class                captured class index
//   frame_err              one-cycle pulse when a malformed frame is discarded
//   frame_cnt              results handed off, wraps modulo 2^CNT_W
module mlp_frame_sequencer #(
  parameter int unsigned NUM_A         = 6,
  parameter int unsigned WIDTH_A       = 4,
  parameter int unsigned OUTWIDTH      = 2,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH_A-1:0]         s_data,
  input  logic                       s_last,
  output logic [NUM_A*WIDTH_A-1:0]   mlp_inp,
  input  logic [OUTWIDTH-1:0]        mlp_out,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [OUTWIDTH-1:0]        m_class,
  output logic                       frame_err,
  output logic [CNT_W-1:0]           frame_cnt
);

  localparam int unsigned FRAME_W = NUM_A * WIDTH_A;
  localparam int unsigned IDX_W   = (NUM_A > 1) ? $clog2(NUM_A) : 1;
  localparam int unsigned SET_W   = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_A - 1);

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [SET_W-1:0]   settle_cnt, settle_cnt_nxt;
  logic [WIDTH_A-1:0] stage [NUM_A];

  logic [FRAME_W-1:0]  mlp_inp_nxt;
  logic                s_ready_nxt;
  logic                m_valid_nxt;
  logic [OUTWIDTH-1:0] m_class_nxt;
  logic                frame_err_nxt;
  logic [CNT_W-1:0]    frame_cnt_nxt;

  logic beat_acc, frame_done, frame_drop, capture, handoff;

  // Event decode shared by the next-state and output logic.
  assign beat_acc   = (state == ST_COLLECT) && s_valid && s_ready;
  assign frame_done = beat_acc && s_last && (idx == LAST_IDX);
  // A beat that is marked last too early, or not marked last in the final slot.
  assign frame_drop = beat_acc && !frame_done && (s_last || (idx == LAST_IDX));
  assign capture    = (state == ST_SETTLE) && (settle_cnt == SET_W'(1));
  assign handoff    = (state == ST_HOLD) && m_valid && m_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_COLLECT: if (frame_done) state_nxt = ST_SETTLE;
      ST_SETTLE:  if (capture)    state_nxt = ST_HOLD;
      ST_HOLD:    if (handoff)    state_nxt = ST_COLLECT;
      default:                    state_nxt = ST_COLLECT;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    idx_nxt        = idx;
    settle_cnt_nxt = settle_cnt;
    mlp_inp_nxt    = mlp_inp;
    m_valid_nxt    = m_valid;
    m_class_nxt    = m_class;
    frame_cnt_nxt  = frame_cnt;
    frame_err_nxt  = 1'b0;
    s_ready_nxt    = (state_nxt == ST_COLLECT);
    unique case (state)
      ST_COLLECT: begin
        if (frame_done) begin
          // Apply the whole frame in one edge so the classifier never sees a partial frame.
          for (int k = 0; k < int'(NUM_A) - 1; k++) begin
            mlp_inp_nxt[k*WIDTH_A +: WIDTH_A] = stage[k];
          end
          mlp_inp_nxt[(NUM_A-1)*WIDTH_A +: WIDTH_A] = s_data;
          settle_cnt_nxt = SET_W'(SETTLE_CYCLES);
          idx_nxt        = '0;
        end else if (frame_drop) begin
          idx_nxt       = '0;
          frame_err_nxt = 1'b1;
        end else if (beat_acc) begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      ST_SETTLE: begin
        settle_cnt_nxt = settle_cnt - SET_W'(1);
        if (capture) begin
          m_class_nxt = mlp_out;
          m_valid_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        if (handoff) begin
          m_valid_nxt   = 1'b0;
          frame_cnt_nxt = frame_cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      settle_cnt <= '0;
      mlp_inp    <= '0;
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_class    <= '0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
      for (int k = 0; k < int'(NUM_A); k++) begin
        stage[k] <= '0;
      end
    end else begin
      idx        <= idx_nxt;
      settle_cnt <= settle_cnt_nxt;
      mlp_inp    <= mlp_inp_nxt;
      s_ready    <= s_ready_nxt;
      m_valid    <= m_valid_nxt;
      m_class    <= m_class_nxt;
      frame_err  <= frame_err_nxt;
      frame_cnt  <= frame_cnt_nxt;
      if (beat_acc) begin
        stage[idx] <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_mlp_frame_sequencer.sv
// Testbench for mlp_frame_sequencer: directed scenarios plus randomized frames,
// checked every cycle against a frame-level behavioural model.
module tb_mlp_frame_sequencer;

  localparam int unsigned NUM_A   = 6;
  localparam int unsigned WIDTH_A = 4;
  localparam int unsigned OUTW    = 2;
  localparam int unsigned SETTLE  = 4;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned FRAME_W = NUM_A * WIDTH_A;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [WIDTH_A-1:0] s_data = '0;
  logic               s_last = 1'b0;
  logic [FRAME_W-1:0] mlp_inp;
  logic [OUTW-1:0]    mlp_out = '0;
  logic               m_valid;
  logic               m_ready = 1'b1;
  logic [OUTW-1:0]    m_class;
  logic               frame_err;
  logic [CNT_W-1:0]   frame_cnt;

  int total = 0;
  int bad = 0;
  int err_seen = 0;
  bit chk_en = 1'b0;
  bit rand_mode = 1'b0;

  mlp_frame_sequencer #(
    .NUM_A(NUM_A), .WIDTH_A(WIDTH_A), .OUTWIDTH(OUTW),
    .SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .mlp_inp(mlp_inp), .mlp_out(mlp_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0 gathering beats, 1 waiting for the classifier, 2 offering result.
  int                 m_phase = 0;
  int                 m_wait = 0;
  logic               exp_ready = 1'b0;
  logic               exp_valid = 1'b0;
  logic [OUTW-1:0]    exp_class = '0;
  logic [FRAME_W-1:0] exp_inp = '0;
  logic               exp_err = 1'b0;
  logic [CNT_W-1:0]   exp_cnt = '0;
  logic [WIDTH_A-1:0] beats[$];
  bit                 was_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_wait = 0;
      exp_ready = 1'b0; exp_valid = 1'b0; exp_class = '0;
      exp_inp = '0; exp_err = 1'b0; exp_cnt = '0;
      beats.delete();
    end else begin
      was_ready = exp_ready;
      exp_err = 1'b0;
      if (m_phase == 0) begin
        if (was_ready && s_valid) begin
          beats.push_back(s_data);
          if (s_last && beats.size() == NUM_A) begin
            for (int k = 0; k < NUM_A; k++) exp_inp[k*WIDTH_A +: WIDTH_A] = beats[k];
            beats.delete();
            m_wait = SETTLE;
            m_phase = 1;
          end else if (s_last || beats.size() == NUM_A) begin
            beats.delete();
            exp_err = 1'b1;
          end
        end
      end else if (m_phase == 1) begin
        m_wait--;
        if (m_wait == 0) begin
          exp_class = mlp_out;
          exp_valid = 1'b1;
          m_phase = 2;
        end
      end else begin
        if (m_ready) begin
          exp_valid = 1'b0;
          exp_cnt = exp_cnt + 1'b1;
          m_phase = 0;
        end
      end
      exp_ready = (m_phase == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (frame_err) err_seen++;
    if (chk_en) begin
      chk("s_ready",   32'(s_ready),   32'(exp_ready));
      chk("m_valid",   32'(m_valid),   32'(exp_valid));
      chk("m_class",   32'(m_class),   32'(exp_class));
      chk("mlp_inp",   32'(mlp_inp),   32'(exp_inp));
      chk("frame_err", 32'(frame_err), 32'(exp_err));
      chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    end
  end

  task automatic rand_drive();
    if (rand_mode) begin
      m_ready = 1'($urandom_range(0, 1));
      mlp_out = OUTW'($urandom_range(0, 3));
    end
  endtask

  // Present one beat; called and returns #1 after a rising edge.
  task automatic send_beat(input logic [WIDTH_A-1:0] d, input logic last);
    int guard = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    while (!s_ready && guard < 200) begin
      @(posedge clk); #1; rand_drive(); guard++;
    end
    if (guard >= 200) chk("beat_timeout", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    rand_drive();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input logic [FRAME_W-1:0] f);
    for (int k = 0; k < NUM_A; k++) send_beat(f[k*WIDTH_A +: WIDTH_A], 1'(k == NUM_A - 1));
  endtask

  // Edges counted from the current point until m_valid is seen high.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!m_valid && n < 50);
    if (!m_valid) chk("valid_timeout", 32'(m_valid), 32'd1);
  endtask

  task automatic nominal(input logic [CNT_W-1:0] cnt_after);
    int n;
    m_ready = 1'b1; mlp_out = 2'd2;
    send_frame(24'h654321);
    chk("nom_inp", 32'(mlp_inp), 32'h654321);
    wait_valid(n);
    chk("nom_latency", 32'(n), 32'd4);
    chk("nom_class", 32'(m_class), 32'd2);
    @(posedge clk); #1;
    chk("nom_cnt", 32'(frame_cnt), 32'(cnt_after));
    chk("nom_ready", 32'(s_ready), 32'd1);
  endtask

  int n, eb;
  int len;
  bit good;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_inp",   32'(mlp_inp), 32'd0);
    chk("rst_cnt",   32'(frame_cnt), 32'd0);
    chk_en = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", 32'(s_ready), 32'd1);

    nominal(16'd1);

    // Classifier output changes after E0+3: sampled at E0+4.
    mlp_out = 2'd0;
    send_frame(24'h111111);
    repeat (3) @(posedge clk);
    #1; mlp_out = 2'd3;
    wait_valid(n);
    chk("cap_late_ok", 32'(m_class), 32'd3);
    @(posedge clk); #1;
    // Change after E0+5: already captured 0.
    mlp_out = 2'd0; m_ready = 1'b0;
    send_frame(24'h222222);
    wait_valid(n);
    @(posedge clk); #1; mlp_out = 2'd3;
    @(posedge clk); #1;
    chk("cap_too_late", 32'(m_class), 32'd0);
    m_ready = 1'b1;
    @(posedge clk); #1;

    // Backpressure with s_valid held high.
    m_ready = 1'b0; mlp_out = 2'd1;
    send_frame(24'h456789);
    wait_valid(n);
    s_valid = 1'b1; s_data = 4'hF; s_last = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("bp_ready", 32'(s_ready), 32'd0);
    chk("bp_valid", 32'(m_valid), 32'd1);
    chk("bp_class", 32'(m_class), 32'd1);
    m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    chk("bp_ready_after", 32'(s_ready), 32'd1);
    chk("bp_cnt", 32'(frame_cnt), 32'd4);

    // Early last then a correct frame.
    eb = err_seen;
    send_beat(4'hA, 1'b0); send_beat(4'hB, 1'b0); send_beat(4'hC, 1'b1);
    @(posedge clk); #1;
    chk("early_inp_kept", 32'(mlp_inp), 32'h456789);
    send_frame(24'h123456);
    chk("early_good_inp", 32'(mlp_inp), 32'h123456);
    wait_valid(n);
    @(posedge clk); #1;
    chk("early_err_pulses", 32'(err_seen - eb), 32'd1);
    chk("early_cnt", 32'(frame_cnt), 32'd5);

    // Missing last.
    eb = err_seen;
    for (int k = 0; k < NUM_A; k++) send_beat(4'(k + 1), 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("miss_err_pulses", 32'(err_seen - eb), 32'd1);
    chk("miss_valid", 32'(m_valid), 32'd0);
    chk("miss_ready", 32'(s_ready), 32'd1);
    chk("miss_inp_kept", 32'(mlp_inp), 32'h123456);

    // Reset two cycles into SETTLE.
    send_frame(24'h333333);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(m_valid), 32'd0);
    chk("rst_mid_inp", 32'(mlp_inp), 32'd0);
    chk("rst_mid_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_mid_ready", 32'(s_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    nominal(16'd1);

    // Randomized frames, gaps, backpressure and classifier output.
    rand_mode = 1'b1;
    for (int f = 0; f < 150; f++) begin
      good = ($urandom_range(0, 3) != 0);
      len = good ? NUM_A : $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1; rand_drive();
        end
        send_beat(4'($urandom_range(0, 15)),
                  good ? 1'(k == len - 1) : 1'((k == len - 1) && ($urandom_range(0, 1) == 1)));
      end
    end
    rand_mode = 1'b0; m_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("final_valid", 32'(m_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
